// File: rtl/mcu.sv
// Main control unit of the music player: turns play/pause and next-song button
// presses into a play enable, the current song index and a restart strobe.
module mcu #(
  parameter int SONG_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play_button,
  input  logic                 next,
  input  logic                 song_done,
  output logic                 play,
  output logic [SONG_BITS-1:0] song,
  output logic                 reset_play
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_NXT   = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   prev_play, prev_next;
  logic   play_press, next_press;

  assign play_press = play_button & ~prev_play;
  assign next_press = next & ~prev_next;

  // prev registers reset high so a button already held at reset release is not a press
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RST;
      prev_play <= 1'b1;
      prev_next <= 1'b1;
      song      <= '0;
    end else begin
      state     <= state_nxt;
      prev_play <= play_button;
      prev_next <= next;
      if (state == ST_NXT) song <= song + SONG_BITS'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    play       = 1'b0;
    reset_play = 1'b0;
    case (state)
      ST_RST: begin
        reset_play = 1'b1;
        state_nxt  = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (next_press)      state_nxt = ST_NXT;
        else if (play_press) state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        play = 1'b1;
        if (song_done)       state_nxt = ST_RST;
        else if (next_press) state_nxt = ST_NXT;
        else if (play_press) state_nxt = ST_PAUSE;
      end
      ST_NXT: begin
        reset_play = 1'b1;
        state_nxt  = ST_PLAY;
      end
      default: state_nxt = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_mcu.sv
// Randomized scoreboard bench for mcu against a behavioural player model.
module tb_mcu;
  localparam int SB     = 2;
  localparam int NSONGS = 1 << SB;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          play_button = 1'b0;
  logic          next = 1'b0;
  logic          song_done = 1'b0;
  logic          play;
  logic [SB-1:0] song;
  logic          reset_play;

  mcu #(.SONG_BITS(SB)) dut (
    .clk(clk), .reset(reset), .play_button(play_button), .next(next),
    .song_done(song_done), .play(play), .song(song), .reset_play(reset_play)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          play;
    logic          rp;
    logic [SB-1:0] song;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Behavioural model of the player as seen from outside
  bit m_playing, m_restarting, m_advance, m_pprev, m_nprev;
  int m_song;

  task automatic model_reset();
    m_playing = 0; m_restarting = 1; m_advance = 0; m_song = 0;
    m_pprev = 1; m_nprev = 1;
  endtask

  task automatic model_step(input bit pb, input bit nx, input bit sd);
    bit pp, np;
    pp = pb && !m_pprev;
    np = nx && !m_nprev;
    m_pprev = pb;
    m_nprev = nx;
    if (m_restarting) begin
      m_restarting = 0;
      if (m_advance) begin
        m_song = (m_song + 1) % NSONGS;
        m_playing = 1;
        m_advance = 0;
      end else begin
        m_playing = 0;
      end
    end else if (m_playing) begin
      if (sd) begin
        m_restarting = 1; m_playing = 0;
      end else if (np) begin
        m_restarting = 1; m_advance = 1; m_playing = 0;
      end else if (pp) begin
        m_playing = 0;
      end
    end else begin
      if (np) begin
        m_restarting = 1; m_advance = 1;
      end else if (pp) begin
        m_playing = 1;
      end
    end
  endtask

  task automatic check_now(input string name, input exp_t e);
    checks++;
    if (play !== e.play || reset_play !== e.rp || song !== e.song) begin
      failures++;
      $display("FAIL %s: got play=%b reset_play=%b song=%0d, expected play=%b reset_play=%b song=%0d",
               name, play, reset_play, song, e.play, e.rp, e.song);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.play = m_playing;
    e.rp   = m_restarting;
    e.song = SB'(m_song);
    return e;
  endfunction

  // One clock of stimulus; expected post-edge outputs go to the scoreboard
  task automatic cyc(input bit rst_v, input bit pb, input bit nx, input bit sd);
    bit was_running;
    @(negedge clk);
    was_running = reset;
    reset = rst_v; play_button = pb; next = nx; song_done = sd;
    if (!rst_v) begin
      model_reset();
      if (was_running) begin
        #1;
        check_now("async_reset", model_out());
      end
    end else begin
      model_step(pb, nx, sd);
    end
    exp_q.push_back(model_out());
  endtask

  // Monitor: compares DUT outputs after every edge against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_now("cycle", e);
      end
    end
  end

  initial begin
    model_reset();
    // reset held with play_button high, then released: not a press
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 0, 0, 0);
    // play press held 3 cycles, release, second press held
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 0, 0, 0);
    // start playing, song_done pulse
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 1); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    // next from pause, then four more nexts to wrap
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 1, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    end
    // song_done and play press together while playing
    cyc(1, 0, 0, 1); cyc(1, 1, 0, 1); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    // get playing on a non-zero song, then reset mid-play
    cyc(1, 0, 1, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 99) != 0),
          ($urandom_range(0, 3) == 0) ? ~play_button : play_button,
          ($urandom_range(0, 4) == 0) ? ~next : next,
          ($urandom_range(0, 7) == 0));
    end
    begin
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 10) begin
        @(posedge clk);
        budget++;
      end
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
